// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: multi-cycle mult/multu/div/divu plus mthi/mtlo,
// owning HI/LO and raising MD_Stall while a result is still pending.
module ex_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] IR_D,
    output logic        Start,
    output logic        Busy,
    output logic        MD_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hiPend;
    logic [31:0]      r_loPend;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [5:0]  w_eOp;
    logic [5:0]  w_eFunct;
    logic [5:0]  w_dOp;
    logic [5:0]  w_dFunct;
    logic        w_unusedIrBits;
    logic        w_eRType;
    logic        w_isMult;
    logic        w_isMultu;
    logic        w_isDiv;
    logic        w_isDivu;
    logic        w_isMthi;
    logic        w_isMtlo;
    logic        w_dHiLo;

    assign w_eOp          = IR_E[31:26];
    assign w_eFunct       = IR_E[5:0];
    assign w_dOp          = IR_D[31:26];
    assign w_dFunct       = IR_D[5:0];
    assign w_unusedIrBits = ^{IR_E[25:6], IR_D[25:6]};

    assign w_eRType  = (w_eOp == 6'h00);
    assign w_isMult  = w_eRType && (w_eFunct == 6'h18);
    assign w_isMultu = w_eRType && (w_eFunct == 6'h19);
    assign w_isDiv   = w_eRType && (w_eFunct == 6'h1A);
    assign w_isDivu  = w_eRType && (w_eFunct == 6'h1B);
    assign w_isMthi  = w_eRType && (w_eFunct == 6'h11);
    assign w_isMtlo  = w_eRType && (w_eFunct == 6'h13);

    // HI/LO class is funct 10h-13h (mfhi..mtlo) or 18h-1Bh (mult..divu)
    assign w_dHiLo = (w_dOp == 6'h00) &&
                     ((w_dFunct[5:2] == 4'b0100) || (w_dFunct[5:2] == 4'b0110));

    assign Start    = w_isMult | w_isMultu | w_isDiv | w_isDivu;
    assign Busy     = (r_state == S_RUN);
    assign MD_Stall = w_dHiLo & (Start | Busy);
    assign HI       = r_hi;
    assign LO       = r_lo;

    logic signed [63:0] w_sA64;
    logic signed [63:0] w_sB64;
    logic signed [63:0] w_sProd;
    logic        [63:0] w_uProd;

    assign w_sA64  = {{32{RD1_E[31]}}, RD1_E};
    assign w_sB64  = {{32{RD2_E[31]}}, RD2_E};
    assign w_sProd = w_sA64 * w_sB64;
    assign w_uProd = {32'h0, RD1_E} * {32'h0, RD2_E};

    // Signed divide through magnitudes: 80000000h/FFFFFFFFh then wraps to
    // LO=80000000h, HI=0 without a special case.
    logic        w_aNeg;
    logic        w_bNeg;
    logic [31:0] w_aMag;
    logic [31:0] w_bMag;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;
    logic [31:0] w_sQuot;
    logic [31:0] w_sRem;
    logic [31:0] w_uQuot;
    logic [31:0] w_uRem;
    logic        w_divZero;

    assign w_aNeg    = RD1_E[31];
    assign w_bNeg    = RD2_E[31];
    assign w_aMag    = w_aNeg ? (~RD1_E + 32'd1) : RD1_E;
    assign w_bMag    = w_bNeg ? (~RD2_E + 32'd1) : RD2_E;
    assign w_qMag    = w_aMag / w_bMag;
    assign w_rMag    = w_aMag % w_bMag;
    assign w_sQuot   = (w_aNeg ^ w_bNeg) ? (~w_qMag + 32'd1) : w_qMag;
    assign w_sRem    = w_aNeg ? (~w_rMag + 32'd1) : w_rMag;
    assign w_uQuot   = RD1_E / RD2_E;
    assign w_uRem    = RD1_E % RD2_E;
    assign w_divZero = (RD2_E == 32'h0);

    logic [31:0]      w_resHi;
    logic [31:0]      w_resLo;
    logic [CNT_W-1:0] w_loadCnt;

    always_comb begin
        w_resHi   = w_uProd[63:32];
        w_resLo   = w_uProd[31:0];
        w_loadCnt = MULT_LOAD;
        if (w_isMult) begin
            w_resHi = w_sProd[63:32];
            w_resLo = w_sProd[31:0];
        end else if (w_isDiv || w_isDivu) begin
            w_loadCnt = DIV_LOAD;
            if (w_divZero) begin
                w_resHi = RD1_E;
                w_resLo = 32'hFFFF_FFFF;
            end else if (w_isDiv) begin
                w_resHi = w_sRem;
                w_resLo = w_sQuot;
            end else begin
                w_resHi = w_uRem;
                w_resLo = w_uQuot;
            end
        end
    end

    // The result is captured at Start; RUN only counts down the latency.
    // HI/LO-class instructions arriving in EX during RUN are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hiPend <= 32'h0;
            r_loPend <= 32'h0;
            r_hi     <= 32'h0;
            r_lo     <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_hiPend <= w_resHi;
                        r_loPend <= w_resLo;
                        r_cnt    <= w_loadCnt;
                        r_state  <= S_RUN;
                    end else begin
                        if (w_isMthi) r_hi <= RD1_E;
                        if (w_isMtlo) r_lo <= RD1_E;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_hi    <= r_hiPend;
                        r_lo    <= r_loPend;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
